// File: rtl/udp_pkg.sv
// Shared UDP receive definitions: FSM states, header length and byte offsets.
package udp_pkg;

  localparam int unsigned UDP_HDR_LEN   = 8;
  localparam int unsigned UDP_HDR_IDX_W = 3;
  localparam int unsigned UDP_BYTE_W    = 8;
  localparam int unsigned UDP_WORD_W    = 16;
  localparam int unsigned UDP_IP_W      = 32;

  // Big-endian header byte offsets (checksum bytes are received but ignored)
  localparam int unsigned UDP_OFF_SP   = 0;
  localparam int unsigned UDP_OFF_DP   = 2;
  localparam int unsigned UDP_OFF_LEN  = 4;
  localparam int unsigned UDP_OFF_CSUM = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } udp_state_e;

  // Captured header fields
  typedef struct packed {
    logic [UDP_WORD_W-1:0] sp;
    logic [UDP_WORD_W-1:0] dp;
    logic [UDP_WORD_W-1:0] len;
  } udp_hdr_t;

endpackage

// File: rtl/udp_rx_if.sv
// Bus bundle for udp_rx: net-layer byte stream in, UDP payload stream and status out.
interface udp_rx_if;
  import udp_pkg::*;

  logic [UDP_BYTE_W-1:0] udp_rnet_data_in;
  logic                  udp_rnet_valid_in;
  logic                  udp_rnet_ready_out;
  logic                  udp_rnet_last_in;
  logic [UDP_IP_W-1:0]   udp_rnet_ip_in;

  logic [UDP_BYTE_W-1:0] udp_rdata_out;
  logic                  udp_rvalid_out;
  logic                  udp_rready_in;
  logic                  udp_rlast_out;
  logic [UDP_IP_W-1:0]   udp_rip_out;
  logic [UDP_WORD_W-1:0] udp_rsp_out;
  logic [UDP_WORD_W-1:0] udp_rlen_out;
  logic                  udp_rerr_out;
  logic [UDP_WORD_W-1:0] frame_ok_cnt_out;
  logic [UDP_WORD_W-1:0] frame_err_cnt_out;

  // Receiver view
  modport slave (
    input  udp_rnet_data_in, udp_rnet_valid_in, udp_rnet_last_in, udp_rnet_ip_in,
    input  udp_rready_in,
    output udp_rnet_ready_out,
    output udp_rdata_out, udp_rvalid_out, udp_rlast_out,
    output udp_rip_out, udp_rsp_out, udp_rlen_out, udp_rerr_out,
    output frame_ok_cnt_out, frame_err_cnt_out
  );

  // Driver / observer view
  modport master (
    output udp_rnet_data_in, udp_rnet_valid_in, udp_rnet_last_in, udp_rnet_ip_in,
    output udp_rready_in,
    input  udp_rnet_ready_out,
    input  udp_rdata_out, udp_rvalid_out, udp_rlast_out,
    input  udp_rip_out, udp_rsp_out, udp_rlen_out, udp_rerr_out,
    input  frame_ok_cnt_out, frame_err_cnt_out
  );

endinterface

// File: rtl/udp_rx.sv
// UDP receive parser: strips the 8-byte header, forwards the payload through a
// one-entry output stage and keeps ok/error frame counters.
// Optional build macro UDP_RX_PORT_FILTER_EN drops frames whose DP != LOCAL_DP.
module udp_rx
  import udp_pkg::*;
#(
  parameter logic [15:0] LOCAL_DP = 16'd8080
) (
  input  logic     logic_clk,
  input  logic     logic_rstn,
  udp_rx_if.slave  bus
);

  udp_state_e                 state_q, state_d;
  udp_hdr_t                   hdr_q, hdr_d;
  logic [UDP_HDR_IDX_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [UDP_WORD_W-1:0]      pay_cnt_q, pay_cnt_d;
  logic [UDP_WORD_W-1:0]      plen_q, plen_d;
  logic                       rvalid_q, rvalid_d;
  logic                       rlast_q, rlast_d;
  logic                       trunc_q, trunc_d;
  logic                       rerr_q, rerr_d;
  logic [UDP_BYTE_W-1:0]      rdata_q, rdata_d;
  logic [UDP_IP_W-1:0]        rip_q, rip_d;
  logic [UDP_WORD_W-1:0]      rsp_q, rsp_d;
  logic [UDP_WORD_W-1:0]      rlen_q, rlen_d;
  logic [UDP_WORD_W-1:0]      ok_cnt_q, ok_cnt_d;
  logic [UDP_WORD_W-1:0]      err_cnt_q, err_cnt_d;

  logic                       ready_c, in_fire_c, out_fire_c;
  logic                       hdr_beat_c, hdr_end_c, pay_beat_c, pay_end_c;
  logic                       len_short_c, len_empty_c, port_reject_c;
  logic [UDP_HDR_IDX_W-1:0]   byte_idx_c;
  logic                       err_c, ok_empty_c, ok_out_c;

  // Handshake and header/payload decode shared by both combinational processes
  always_comb begin
    ready_c     = logic_rstn && ((state_q != ST_PAYLOAD) || !rvalid_q || bus.udp_rready_in);
    in_fire_c   = bus.udp_rnet_valid_in && ready_c;
    out_fire_c  = rvalid_q && bus.udp_rready_in;
    byte_idx_c  = (state_q == ST_IDLE) ? '0 : hdr_cnt_q;
    hdr_beat_c  = in_fire_c && ((state_q == ST_IDLE) || (state_q == ST_HDR));
    hdr_end_c   = hdr_beat_c && (byte_idx_c == UDP_HDR_IDX_W'(UDP_HDR_LEN - 1));
    pay_beat_c  = in_fire_c && (state_q == ST_PAYLOAD);
    pay_end_c   = ((pay_cnt_q + 16'd1) == plen_q);
    len_short_c = hdr_q.len < UDP_WORD_W'(UDP_HDR_LEN);
    len_empty_c = hdr_q.len == UDP_WORD_W'(UDP_HDR_LEN);
`ifdef UDP_RX_PORT_FILTER_EN
    port_reject_c = (hdr_q.dp != LOCAL_DP);
`else
    // DP is still compared but the result is ignored in this build
    port_reject_c = 1'b0 && (hdr_q.dp != LOCAL_DP);
`endif
  end

  // State register
  always_ff @(posedge logic_clk) begin
    if (!logic_rstn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire_c) state_d = bus.udp_rnet_last_in ? ST_IDLE : ST_HDR;
      end
      ST_HDR: begin
        if (in_fire_c) begin
          if (bus.udp_rnet_last_in) state_d = ST_IDLE;
          else if (hdr_end_c)       state_d = (len_short_c || len_empty_c || port_reject_c)
                                              ? ST_DROP : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (in_fire_c) begin
          if (bus.udp_rnet_last_in) state_d = ST_IDLE;
          else if (pay_end_c)       state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (in_fire_c && bus.udp_rnet_last_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, output stage and counter updates
  always_comb begin
    hdr_d      = hdr_q;
    hdr_cnt_d  = hdr_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    plen_d     = plen_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    trunc_d    = trunc_q;
    rdata_d    = rdata_q;
    rip_d      = rip_q;
    rsp_d      = rsp_q;
    rlen_d     = rlen_q;
    err_c      = 1'b0;
    ok_empty_c = 1'b0;

    if (hdr_beat_c) begin
      hdr_cnt_d = byte_idx_c + 3'd1;
      case (byte_idx_c)
        UDP_HDR_IDX_W'(UDP_OFF_SP):       hdr_d.sp[15:8]  = bus.udp_rnet_data_in;
        UDP_HDR_IDX_W'(UDP_OFF_SP + 1):   hdr_d.sp[7:0]   = bus.udp_rnet_data_in;
        UDP_HDR_IDX_W'(UDP_OFF_DP):       hdr_d.dp[15:8]  = bus.udp_rnet_data_in;
        UDP_HDR_IDX_W'(UDP_OFF_DP + 1):   hdr_d.dp[7:0]   = bus.udp_rnet_data_in;
        UDP_HDR_IDX_W'(UDP_OFF_LEN):      hdr_d.len[15:8] = bus.udp_rnet_data_in;
        UDP_HDR_IDX_W'(UDP_OFF_LEN + 1):  hdr_d.len[7:0]  = bus.udp_rnet_data_in;
        default: ;
      endcase
    end

    if (hdr_end_c) begin
      pay_cnt_d = '0;
      plen_d    = hdr_q.len - UDP_WORD_W'(UDP_HDR_LEN);
      if (len_short_c)                         err_c      = 1'b1;
      else if (len_empty_c)                    ok_empty_c = 1'b1;
      else if (!port_reject_c && bus.udp_rnet_last_in) err_c = 1'b1;
    end else if (hdr_beat_c && bus.udp_rnet_last_in) begin
      err_c = 1'b1;
    end

    if (out_fire_c) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
      trunc_d  = 1'b0;
    end

    if (pay_beat_c) begin
      pay_cnt_d = pay_cnt_q + 16'd1;
      rvalid_d  = 1'b1;
      rdata_d   = bus.udp_rnet_data_in;
      rlast_d   = bus.udp_rnet_last_in || pay_end_c;
      trunc_d   = bus.udp_rnet_last_in && !pay_end_c;
      rip_d     = bus.udp_rnet_ip_in;
      rsp_d     = hdr_q.sp;
      rlen_d    = plen_q;
      if (bus.udp_rnet_last_in && !pay_end_c) err_c = 1'b1;
    end

    ok_out_c  = out_fire_c && rlast_q && !trunc_q;
    rerr_d    = err_c;
    ok_cnt_d  = ok_cnt_q + UDP_WORD_W'(ok_out_c) + UDP_WORD_W'(ok_empty_c);
    err_cnt_d = err_cnt_q + UDP_WORD_W'(err_c);
  end

  // Datapath registers
  always_ff @(posedge logic_clk) begin
    if (!logic_rstn) begin
      hdr_q     <= '0;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      plen_q    <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      trunc_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      rip_q     <= '0;
      rsp_q     <= '0;
      rlen_q    <= '0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      hdr_q     <= hdr_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      plen_q    <= plen_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      trunc_q   <= trunc_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      rip_q     <= rip_d;
      rsp_q     <= rsp_d;
      rlen_q    <= rlen_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.udp_rnet_ready_out = ready_c;
  assign bus.udp_rdata_out      = rdata_q;
  assign bus.udp_rvalid_out     = rvalid_q;
  assign bus.udp_rlast_out      = rlast_q;
  assign bus.udp_rip_out        = rip_q;
  assign bus.udp_rsp_out        = rsp_q;
  assign bus.udp_rlen_out       = rlen_q;
  assign bus.udp_rerr_out       = rerr_q;
  assign bus.frame_ok_cnt_out   = ok_cnt_q;
  assign bus.frame_err_cnt_out  = err_cnt_q;

endmodule
